operand_b_select_pipe: RTL and testbench
========================================

Name: operand_b_select_pipe

Overview:
- Registered, parametrised successor to the ALU operand-B select mux.
- Takes a one-hot decoded opcode, a register operand (RF[RS2]) and an immediate, and chooses between pass, sign-extend, zero/pass-immediate and forced-zero.
- Result goes out through a valid/ready pipeline stage with a 2-entry skid buffer.
- Sits between decode and the ALU/EX stage; adds illegal/multi-hot opcode detection and a "hold last operand" fallback.

Parameters:
- DATA_W, 32: operand width.
- IMM_W, 16: significant immediate width for sign extension; must be ≤ DATA_W.
- SEL_W, 20: one-hot opcode select width.
- TAG_W, 5: sideband tag (destination register) carried with each operand.
- REG_MASK, 20'hC0073: select bits choosing the register operand (ADD, SUB, SGE, SLE, SEQ, ADDF, MULF).
- SEXT_MASK, 20'h00600: select bits choosing the sign-extended immediate.
- IMM_MASK, 20'h0218C: select bits choosing the immediate unmodified (LOAD, STORE, SLI, SRI, MOVEI).
- ZERO_MASK, 20'h01800: select bits forcing zero (NOP, MOVE).

Ports:
- clk, input, 1: clock; all state changes on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: input beat valid.
- in_ready, output, 1: stage can accept a beat.
- in_sel, input, SEL_W: one-hot opcode select.
- in_reg, input, DATA_W: register operand.
- in_imm, input, DATA_W: immediate operand.
- in_tag, input, TAG_W: sideband tag.
- out_valid, output, 1: output beat valid.
- out_ready, input, 1: consumer accepts the beat.
- out_operand, output, DATA_W: selected operand B.
- out_tag, output, TAG_W: tag of the beat.
- out_illegal, output, 1: the beat's select matched no mask.
- out_multi, output, 1: the beat's select had more than one bit set.
- illegal_count, output, 16: saturating count of accepted illegal beats.

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect at any time including mid-transfer):
  - out_valid=0, out_operand=0, out_tag=0, out_illegal=0, out_multi=0.
  - in_ready=0 while reset is asserted; in_ready=1 from the first edge after release.
  - Skid entry is emptied, the last-operand register is 0 and illegal_count=0.
  - In-flight beats are discarded.
- Acceptance: a beat is accepted when in_valid&&in_ready at a clock edge. Output transfer occurs when out_valid&&out_ready.
- Selection, evaluated combinationally on the input beat at acceptance, fixed priority:
  1. in_sel & REG_MASK non-zero → in_reg.
  2. Else in_sel & SEXT_MASK → {(DATA_W-IMM_W){in_imm[IMM_W-1]}, in_imm[IMM_W-1:0]}. Upper input bits are ignored.
  3. Else in_sel & IMM_MASK → in_imm unmodified.
  4. Else in_sel & ZERO_MASK → 0.
  5. Else (no match, including in_sel==0) → value of the last-operand register, with illegal=1.
- The last-operand register is updated with the selected value on every accepted legal beat. Illegal beats do not update it.
- multi=1 when popcount(in_sel)>1. The priority result is still used; multi does not imply illegal.
- illegal_count increments on each accepted illegal beat and saturates at 16'hFFFF.
- Latency: exactly 1 cycle from acceptance to out_valid when the output register is empty or draining.
- State machine (main output register M, skid register S):
  - EMPTY: in_ready=1, out_valid=0. Accept → ONE.
  - ONE: in_ready=1, out_valid=1.
    - Accept with out_ready → stay in ONE; M reloads.
    - Accept without out_ready → FULL; beat goes into S.
    - No accept with out_ready → EMPTY.
  - FULL: in_ready=0, out_valid=1. out_ready → S moves into M, → ONE.
- in_ready is a registered function of state; it does not depend combinationally on out_ready.
- Output stability: while out_valid=1 and out_ready=0, out_operand, out_tag, out_illegal and out_multi hold stable.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.

Test Plan:
- Reset then single beat: in_sel=20'h00001, in_reg=32'h1234_5678 → one cycle later out_valid=1, out_operand=32'h1234_5678, illegal=0, multi=0.
- Sign extension: in_sel bit9, in_imm=32'h0000_8001 → out_operand=32'hFFFF_8001. Repeat with in_imm=32'hABCD_7FFF → out_operand=32'h0000_7FFF.
- Immediate pass and zero:
  - bit13 with in_imm=32'hABCD_7FFF → 32'hABCD_7FFF.
  - bit11 → 32'h0000_0000.
  - bits {0,9} set → in_reg chosen, out_multi=1.
- Illegal hold: legal beat produces 32'h0000_00AA, then in_sel=0 → out_operand=32'h0000_00AA, out_illegal=1, illegal_count=1. Force 65536 illegal beats → count saturates at 16'hFFFF.
- Backpressure: out_ready=0 while 3 beats are offered back-to-back → first two accepted, in_ready=0 on the third, outputs stable. Release out_ready → beats emerge in order and the third is then accepted.
- Async reset mid-FULL: assert rst_n=0 between edges → out_valid=0 and illegal_count=0 immediately. After release, in_ready=1 and no stale beat emerges.

Source files
------------

// File: rtl/operand_b_select_pipe.sv
// Operand-B select stage: picks register / sign-extended immediate /
// raw immediate / zero from a one-hot opcode, flags illegal and multi-hot
// selects, and presents the result through a valid/ready stage with a
// one-entry skid register behind the main output register.
module operand_b_select_pipe #(
    parameter int unsigned      DATA_W    = 32,
    parameter int unsigned      IMM_W     = 16,
    parameter int unsigned      SEL_W     = 20,
    parameter int unsigned      TAG_W     = 5,
    parameter logic [SEL_W-1:0] REG_MASK  = 20'hC0073,
    parameter logic [SEL_W-1:0] SEXT_MASK = 20'h00600,
    parameter logic [SEL_W-1:0] IMM_MASK  = 20'h0218C,
    parameter logic [SEL_W-1:0] ZERO_MASK = 20'h01800
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_sel,
    input  logic [DATA_W-1:0] in_reg,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_operand,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_illegal,
    output logic              out_multi,
    output logic [15:0]       illegal_count
);

    // Beat layout: {illegal, multi, tag, operand}
    localparam int unsigned BEAT_W = DATA_W + TAG_W + 2;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_ONE,
        ST_FULL
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [BEAT_W-1:0]   r_m_beat;
    logic [BEAT_W-1:0]   r_s_beat;
    logic [DATA_W-1:0]   r_last;
    logic [15:0]         r_cnt;

    logic [DATA_W-1:0]   w_sext;
    logic [DATA_W-1:0]   w_sel_val;
    logic                w_illegal;
    logic                w_multi;
    logic [BEAT_W-1:0]   w_beat;
    logic                w_accept;

    assign w_accept = in_valid && r_in_ready;
    // Size cast of a signed slice sign-extends and stays legal when IMM_W == DATA_W
    assign w_sext   = DATA_W'($signed(in_imm[IMM_W-1:0]));

    // Priority operand selection; unmatched selects replay the last legal operand
    always_comb begin
        w_illegal = 1'b0;
        if (|(in_sel & REG_MASK)) begin
            w_sel_val = in_reg;
        end else if (|(in_sel & SEXT_MASK)) begin
            w_sel_val = w_sext;
        end else if (|(in_sel & IMM_MASK)) begin
            w_sel_val = in_imm;
        end else if (|(in_sel & ZERO_MASK)) begin
            w_sel_val = '0;
        end else begin
            w_sel_val = r_last;
            w_illegal = 1'b1;
        end
        w_multi = |(in_sel & (in_sel - SEL_W'(1)));
        w_beat  = {w_illegal, w_multi, in_tag, w_sel_val};
    end

    // Output handshake FSM: main register M plus skid register S
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_m_beat    <= '0;
            r_s_beat    <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_m_beat    <= w_beat;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && out_ready) begin
                        r_m_beat <= w_beat;
                    end else if (w_accept) begin
                        r_s_beat   <= w_beat;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_FULL;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        r_m_beat   <= r_s_beat;
                        r_in_ready <= 1'b1;
                        r_state    <= ST_ONE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_EMPTY;
                end
            endcase
        end
    end

    // Last legal operand and saturating illegal-beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            if (w_illegal) begin
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end else begin
                r_last <= w_sel_val;
            end
        end
    end

    assign in_ready      = r_in_ready;
    assign out_valid     = r_out_valid;
    assign out_operand   = r_m_beat[DATA_W-1:0];
    assign out_tag       = r_m_beat[DATA_W +: TAG_W];
    assign out_multi     = r_m_beat[DATA_W + TAG_W];
    assign out_illegal   = r_m_beat[DATA_W + TAG_W + 1];
    assign illegal_count = r_cnt;

endmodule

// File: tb/tb_operand_b_select_pipe.sv
// Bench for operand_b_select_pipe: directed vectors with literal
// expectations, plus an in-flight beat queue model checked every cycle.
module tb_operand_b_select_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_sel = '0;
    logic [31:0] in_reg = '0;
    logic [31:0] in_imm = '0;
    logic [4:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_operand;
    logic [4:0]  out_tag;
    logic        out_illegal;
    logic        out_multi;
    logic [15:0] illegal_count;

    always #5 clk = ~clk;

    operand_b_select_pipe #(
        .DATA_W (32),
        .IMM_W  (16),
        .SEL_W  (20),
        .TAG_W  (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sel        (in_sel),
        .in_reg        (in_reg),
        .in_imm        (in_imm),
        .in_tag        (in_tag),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_operand   (out_operand),
        .out_tag       (out_tag),
        .out_illegal   (out_illegal),
        .out_multi     (out_multi),
        .illegal_count (illegal_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", name, got, exp);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] op;
        logic [4:0]  tag;
        logic        ill;
        logic        mul;
    } beat_t;

    beat_t       q[$];
    logic [31:0] m_last = '0;
    int          m_cnt  = 0;
    logic        tb_up  = 1'b0;

    function automatic beat_t model(input logic [19:0] sel, input logic [31:0] r,
                                    input logic [31:0] imm, input logic [4:0] tag,
                                    input logic [31:0] last);
        beat_t b;
        int ones = 0;
        for (int i = 0; i < 20; i++) ones += int'(sel[i]);
        b.tag = tag;
        b.mul = (ones > 1);
        b.ill = 1'b0;
        if ((sel & 20'hC0073) != 0)      b.op = r;
        else if ((sel & 20'h00600) != 0) b.op = {{16{imm[15]}}, imm[15:0]};
        else if ((sel & 20'h0218C) != 0) b.op = imm;
        else if ((sel & 20'h01800) != 0) b.op = 32'h0;
        else begin
            b.op  = last;
            b.ill = 1'b1;
        end
        return b;
    endfunction

    // in_ready may only rise on the first clock edge after reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_up <= 1'b0;
        else        tb_up <= 1'b1;
    end

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_last = '0;
            m_cnt  = 0;
            chk1("rst_out_valid", out_valid, 1'b0);
            chk1("rst_in_ready", in_ready, 1'b0);
            chk("rst_count", 32'(illegal_count), 32'h0);
            chk("rst_operand", out_operand, 32'h0);
        end else begin
            chk1("m_in_ready", in_ready, tb_up && (q.size() < 2));
            chk1("m_out_valid", out_valid, q.size() != 0);
            chk("m_count", 32'(illegal_count), 32'(m_cnt));
            if (out_valid && q.size() != 0) begin
                chk("m_operand", out_operand, q[0].op);
                chk("m_tag", 32'(out_tag), 32'(q[0].tag));
                chk1("m_illegal", out_illegal, q[0].ill);
                chk1("m_multi", out_multi, q[0].mul);
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                beat_t b;
                b = model(in_sel, in_reg, in_imm, in_tag, m_last);
                q.push_back(b);
                if (b.ill) begin
                    if (m_cnt < 65535) m_cnt++;
                end else begin
                    m_last = b.op;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [19:0] sel, input logic [31:0] r,
                        input logic [31:0] imm, input logic [4:0] tag);
        bit acc = 1'b0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_reg   = r;
        in_imm   = imm;
        in_tag   = tag;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: in_ready low for 50 cycles, want accept");
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b0);
        chk("reset_operand", out_operand, 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk1("in_ready_after_release", in_ready, 1'b1);

        // Main selection patterns
        send(20'h00001, 32'h1234_5678, 32'h0, 5'd1);
        chk1("single_valid", out_valid, 1'b1);
        chk("single_operand", out_operand, 32'h1234_5678);
        chk1("single_illegal", out_illegal, 1'b0);
        chk1("single_multi", out_multi, 1'b0);
        send(20'h00200, 32'hDEAD_BEEF, 32'h0000_8001, 5'd2);
        chk("sext_neg", out_operand, 32'hFFFF_8001);
        send(20'h00200, 32'hDEAD_BEEF, 32'hABCD_7FFF, 5'd3);
        chk("sext_pos", out_operand, 32'h0000_7FFF);
        send(20'h02000, 32'hDEAD_BEEF, 32'hABCD_7FFF, 5'd4);
        chk("imm_pass", out_operand, 32'hABCD_7FFF);
        send(20'h00800, 32'hDEAD_BEEF, 32'hABCD_7FFF, 5'd5);
        chk("zero", out_operand, 32'h0);
        send(20'h00201, 32'hCAFE_BABE, 32'h0000_0001, 5'd6);
        chk("multi_operand", out_operand, 32'hCAFE_BABE);
        chk1("multi_flag", out_multi, 1'b1);
        chk1("multi_not_illegal", out_illegal, 1'b0);
        send(20'h00400, 32'h0, 32'h1234_FFFF, 5'd7);
        chk("sext_bit10", out_operand, 32'hFFFF_FFFF);
        idle(2);

        // Illegal hold and counter saturation
        pulse_reset();
        send(20'h00001, 32'h0000_00AA, 32'h0, 5'd8);
        chk("legal_aa", out_operand, 32'h0000_00AA);
        send(20'h00000, 32'h0000_0055, 32'h0000_0066, 5'd9);
        chk("hold_operand", out_operand, 32'h0000_00AA);
        chk1("hold_illegal", out_illegal, 1'b1);
        chk("hold_count", 32'(illegal_count), 32'h1);
        send(20'h04000, 32'h0000_0055, 32'h0000_0066, 5'd10);
        chk("unmapped_bit_count", 32'(illegal_count), 32'h2);
        send(20'h00008, 32'h0, 32'h0000_0077, 5'd11);
        chk("imm_bit3", out_operand, 32'h0000_0077);
        for (int i = 0; i < 65536; i++) send(20'h00000, 32'h0, 32'h0, 5'(i));
        chk("sat_count", 32'(illegal_count), 32'h0000_FFFF);
        chk("sat_hold_operand", out_operand, 32'h0000_0077);
        idle(2);

        // Backpressure: two accepted, third stalls until drain
        out_ready = 1'b0;
        send(20'h00001, 32'h0000_0111, 32'h0, 5'd1);
        send(20'h00010, 32'h0000_0222, 32'h0, 5'd2);
        in_valid = 1'b1;
        in_sel   = 20'h00040;
        in_reg   = 32'h0000_0333;
        in_tag   = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("bp_in_ready_low", in_ready, 1'b0);
            chk("bp_stable_operand", out_operand, 32'h0000_0111);
            chk("bp_stable_tag", 32'(out_tag), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(20'h00040, 32'h0000_0333, 32'h0, 5'd3);
        chk("bp_third_accepted", out_operand, 32'h0000_0333);
        idle(3);

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        send(20'h00000, 32'h0, 32'h0, 5'd12);
        send(20'h00000, 32'h0, 32'h0, 5'd13);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk1("arst_out_valid", out_valid, 1'b0);
        chk("arst_count", 32'(illegal_count), 32'h0);
        chk1("arst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk1("arst_release_ready", in_ready, 1'b1);
        chk1("arst_release_valid", out_valid, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk1("arst_no_stale", out_valid, 1'b0);
        end
        send(20'h00000, 32'h0000_1111, 32'h0000_2222, 5'd14);
        chk("arst_last_cleared", out_operand, 32'h0);
        chk1("arst_last_illegal", out_illegal, 1'b1);
        send(20'h00001, 32'h0000_0099, 32'h0, 5'd15);
        chk("arst_resume", out_operand, 32'h0000_0099);
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
